// File: rtl/wb_write_queue_pkg.sv
// ============================================================================
// Module      : wb_write_queue_pkg
// Description : Shared widths, the PC register number and the queue entry type.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package wb_write_queue_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] PC_REG = 4'hF;

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } wb_entry;

endpackage

`default_nettype wire

// File: rtl/wb_fwd_match.sv
// ============================================================================
// Module      : wb_fwd_match
// Description : Youngest-match search of one source register over queued entries.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wb_fwd_match
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  wb_entry           entries [0:DEPTH-1],
  input  logic [AW-1:0]     head,
  input  logic [AW:0]       count,
  input  logic [REG_W-1:0]  src,
  output logic              hit,
  output logic [DATA_W-1:0] value
);

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((AW+1)'(i) < count) && (src != PC_REG) &&
          (entries[head + AW'(i)].dest == src)) begin
        hit   = 1'b1;
        value = entries[head + AW'(i)].value;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_write_queue.sv
// ============================================================================
// Module      : wb_write_queue
// Description : In-order write-back queue feeding the register file write port,
//               with per-source forwarding of queued results.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_push,
  input  logic [3:0]        ld_dest,
  input  logic [31:0]       ld_value,
  input  logic              alu_push,
  input  logic [3:0]        alu_dest,
  input  logic [31:0]       alu_value,
  input  logic [3:0]        src1,
  input  logic [3:0]        src2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [31:0]       fwd1_value,
  output logic [31:0]       fwd2_value,
  output logic              writeBackEn,
  output logic [3:0]        WB_Dest,
  output logic [31:0]       WB_Value,
  output logic              full,
  output logic              overflow,
  output logic [AW:0]       count
);

  wb_entry       r_mem [0:DEPTH-1];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic          w_pop;
  logic [AW+1:0] w_free;
  logic          w_ld_ok;
  logic          w_alu_ok;
  logic          w_ld_acc;
  logic          w_alu_acc;
  logic          w_drop;
  wb_entry       w_head_entry;

  assign w_pop    = (r_count != '0);
  // The slot retiring this cycle can be refilled in the same cycle.
  assign w_free   = (AW+2)'(DEPTH) - (AW+2)'(r_count) + (AW+2)'(w_pop);
  assign w_ld_ok  = ld_push  && (ld_dest  != PC_REG);
  assign w_alu_ok = alu_push && (alu_dest != PC_REG);

  assign w_ld_acc  = w_ld_ok  && (w_free != '0);
  assign w_alu_acc = w_alu_ok && (w_free > (AW+2)'(w_ld_acc));
  assign w_drop    = (w_ld_ok && !w_ld_acc) || (w_alu_ok && !w_alu_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_head     <= r_head + AW'(w_pop);
      r_tail     <= r_tail + AW'(w_ld_acc) + AW'(w_alu_acc);
      r_count    <= r_count + (AW+1)'(w_ld_acc) + (AW+1)'(w_alu_acc) - (AW+1)'(w_pop);
      r_overflow <= r_overflow | w_drop;
    end
  end

  // Storage is left uncleared by reset; validity comes from head/count only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_ld_acc)
        r_mem[r_tail] <= '{dest: ld_dest, value: ld_value};
      if (w_alu_acc)
        r_mem[r_tail + AW'(w_ld_acc)] <= '{dest: alu_dest, value: alu_value};
    end
  end

  assign w_head_entry = r_mem[r_head];
  assign writeBackEn  = w_pop;
  assign WB_Dest      = w_pop ? w_head_entry.dest  : '0;
  assign WB_Value     = w_pop ? w_head_entry.value : '0;
  assign full         = (((AW+1)'(DEPTH) - r_count) < (AW+1)'(2));
  assign overflow     = r_overflow;
  assign count        = r_count;

  wb_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_fwd1 (
    .entries (r_mem),
    .head    (r_head),
    .count   (r_count),
    .src     (src1),
    .hit     (fwd1_hit),
    .value   (fwd1_value)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_fwd2 (
    .entries (r_mem),
    .head    (r_head),
    .count   (r_count),
    .src     (src2),
    .hit     (fwd2_hit),
    .value   (fwd2_value)
  );

endmodule

`default_nettype wire

// File: tb/tb_wb_write_queue.sv
// ============================================================================
// Module      : tb_wb_write_queue
// Description : Scenario tasks plus a write-back scoreboard for wb_write_queue.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_push, alu_push;
  logic [3:0]  ld_dest, alu_dest, src1, src2;
  logic [31:0] ld_value, alu_value;
  logic        fwd1_hit, fwd2_hit, writeBackEn, full, overflow;
  logic [31:0] fwd1_value, fwd2_value, WB_Value;
  logic [3:0]  WB_Dest;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [35:0] sb [$];

  wb_write_queue #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .ld_push(ld_push), .ld_dest(ld_dest), .ld_value(ld_value),
    .alu_push(alu_push), .alu_dest(alu_dest), .alu_value(alu_value),
    .src1(src1), .src2(src2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_value(fwd1_value), .fwd2_value(fwd2_value),
    .writeBackEn(writeBackEn), .WB_Dest(WB_Dest), .WB_Value(WB_Value),
    .full(full), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  // Every write-back seen at the port must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && writeBackEn) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got R%0d=%h, expected nothing", WB_Dest, WB_Value);
      end else begin
        logic [35:0] exp;
        exp = sb.pop_front();
        if ({WB_Dest, WB_Value} !== exp) begin
          n_fail++;
          $display("FAIL wb_order: got R%0d=%h, expected R%0d=%h",
                   WB_Dest, WB_Value, exp[35:32], exp[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_push = 0; alu_push = 0;
    ld_dest = 0; alu_dest = 0; ld_value = 0; alu_value = 0;
  endtask

  task automatic push_ld(input logic [3:0] d, input logic [31:0] v, input bit expect_acc);
    ld_push = 1; ld_dest = d; ld_value = v;
    if (expect_acc) sb.push_back({d, v});
  endtask

  task automatic push_alu(input logic [3:0] d, input logic [31:0] v, input bit expect_acc);
    alu_push = 1; alu_dest = d; alu_value = v;
    if (expect_acc) sb.push_back({d, v});
  endtask

  task automatic test_reset();
    rst = 1; src1 = 1; src2 = 2;
    ld_push = 1; ld_dest = 1; ld_value = 32'h1;
    alu_push = 1; alu_dest = 2; alu_value = 32'h2;
    tick(); tick();
    n_tests++;
    if (count !== 3'd0 || writeBackEn !== 1'b0 || overflow !== 1'b0 || full !== 1'b0 ||
        WB_Dest !== 4'd0 || WB_Value !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d wben=%b ovf=%b full=%b dest=%0d val=%h, expected all 0",
               count, writeBackEn, overflow, full, WB_Dest, WB_Value);
    end
    n_tests++;
    if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0 || fwd1_value !== 32'd0 || fwd2_value !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_fwd: hit1=%b hit2=%b v1=%h v2=%h, expected 0", fwd1_hit, fwd2_hit,
               fwd1_value, fwd2_value);
    end
    rst = 0; idle_inputs();
    tick();
    n_tests++;
    if (writeBackEn !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release: wben=%b count=%0d, expected 0/0", writeBackEn, count);
    end
    // Reset with entries queued discards them.
    push_ld(4'd6, 32'h66, 1); push_alu(4'd7, 32'h77, 1);
    tick();
    idle_inputs(); rst = 1;
    tick();
    sb.delete();
    rst = 0;
    tick();
    n_tests++;
    if (count !== 3'd0 || writeBackEn !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop: count=%0d wben=%b, expected 0/0", count, writeBackEn);
    end
  endtask

  task automatic test_single();
    push_alu(4'd3, 32'h0000_00AA, 1);
    tick();
    idle_inputs();
    n_tests++;
    if (writeBackEn !== 1'b1 || WB_Dest !== 4'd3 || WB_Value !== 32'hAA || count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_port: wben=%b R%0d=%h count=%0d, expected 1 R3=aa 1",
               writeBackEn, WB_Dest, WB_Value, count);
    end
    tick();
    n_tests++;
    if (writeBackEn !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_drain: wben=%b count=%0d, expected 0/0", writeBackEn, count);
    end
  endtask

  task automatic test_dual();
    logic [3:0] exp_dest [3];
    logic [2:0] exp_cnt  [3];
    exp_dest = '{4'd1, 4'd2, 4'd0};
    exp_cnt  = '{3'd2, 3'd1, 3'd0};
    push_ld(4'd1, 32'h11, 1); push_alu(4'd2, 32'h22, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_inputs();
      n_tests++;
      if (count !== exp_cnt[i] || WB_Dest !== exp_dest[i]) begin
        n_fail++;
        $display("FAIL dual_step%0d: count=%0d dest=%0d, expected %0d/%0d",
                 i, count, WB_Dest, exp_cnt[i], exp_dest[i]);
      end
    end
  endtask

  task automatic test_fwd();
    src1 = 5; src2 = 4;
    push_ld(4'd5, 32'h5, 1); push_alu(4'd5, 32'h6, 1);
    #1;
    n_tests++;
    if (fwd1_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_same_cycle: hit1=%b, expected 0", fwd1_hit);
    end
    tick();
    idle_inputs();
    n_tests++;
    if (fwd1_hit !== 1'b1 || fwd1_value !== 32'h6 || fwd2_hit !== 1'b0 || fwd2_value !== 32'h0) begin
      n_fail++;
      $display("FAIL fwd_youngest: hit1=%b v1=%h hit2=%b v2=%h, expected 1 6 0 0",
               fwd1_hit, fwd1_value, fwd2_hit, fwd2_value);
    end
    tick();
    n_tests++;
    if (fwd1_hit !== 1'b1 || fwd1_value !== 32'h6) begin
      n_fail++;
      $display("FAIL fwd_tail_only: hit1=%b v1=%h, expected 1 6", fwd1_hit, fwd1_value);
    end
    tick();
    n_tests++;
    if (fwd1_hit !== 1'b0 || fwd1_value !== 32'h0) begin
      n_fail++;
      $display("FAIL fwd_retired: hit1=%b v1=%h, expected 0 0", fwd1_hit, fwd1_value);
    end
  endtask

  task automatic test_capacity();
    push_ld(4'd1, 32'hA1, 1); push_alu(4'd2, 32'hA2, 1);
    tick();
    n_tests++;
    if (count !== 3'd2 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL cap_two: count=%0d full=%b, expected 2/0", count, full);
    end
    push_ld(4'd3, 32'hA3, 1); push_alu(4'd4, 32'hA4, 1);
    tick();
    n_tests++;
    if (count !== 3'd3 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_full: count=%0d full=%b, expected 3/1", count, full);
    end
    push_ld(4'd6, 32'hA6, 1); push_alu(4'd7, 32'hA7, 1);
    tick();
    n_tests++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL cap_reuse: count=%0d ovf=%b, expected 4/0", count, overflow);
    end
    push_ld(4'd8, 32'hA8, 1); push_alu(4'd9, 32'hA9, 0);
    tick();
    idle_inputs();
    n_tests++;
    if (count !== 3'd4 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_drop: count=%0d ovf=%b, expected 4/1", count, overflow);
    end
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (count !== 3'd0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_sticky: count=%0d ovf=%b, expected 0/1", count, overflow);
    end
    rst = 1;
    tick();
    rst = 0;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL cap_ovf_clear: ovf=%b, expected 0", overflow);
    end
  endtask

  task automatic test_pc_wrap();
    push_ld(4'hF, 32'hDEAD, 0); push_alu(4'hF, 32'hBEEF, 0);
    tick();
    idle_inputs();
    n_tests++;
    if (count !== 3'd0 || writeBackEn !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL pc_ignored: count=%0d wben=%b ovf=%b, expected 0/0/0", count, writeBackEn, overflow);
    end
    src1 = 4'hF;
    for (int i = 0; i < 10; i++) begin
      push_alu(4'(i), 32'h100 + 32'(i), 1);
      src2 = 4'(i);
      tick();
      idle_inputs();
      n_tests++;
      if (count !== 3'd1 || WB_Dest !== 4'(i) || fwd2_hit !== 1'b1 ||
          fwd2_value !== 32'h100 + 32'(i) || fwd1_hit !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_R%0d: count=%0d dest=%0d hit2=%b v2=%h hit1=%b",
                 i, count, WB_Dest, fwd2_hit, fwd2_value, fwd1_hit);
      end
    end
    tick();
    n_tests++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_drain: count=%0d, expected 0", count);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1; src1 = 0; src2 = 0;
    test_reset();
    test_single();
    test_dual();
    test_fwd();
    test_capacity();
    test_pc_wrap();
    tick();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d results never written back, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
